// File: rtl/ff_conv_pkg.sv
// Shared definitions for the flip-flop conversion set: checker FSM states,
// default counter width and a saturating increment helper.
package ff_conv_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } ff_state_e;

    // Default width of the saturating error and toggle counters.
    localparam int CNT_W_DEFAULT = 8;

    // Returns val+1, or val unchanged once it has reached 2^width-1.
    // Widths from 1 to 32 are supported; callers truncate the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        sat_inc = (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/dff_cell.sv
// Plain D flip-flop with synchronous active-low reset to 0. Used as the
// storage element behind each converted SR, JK and T flop.
module dff_cell (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Capture d every rising edge; reset to 0 while rst is low.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        // NOTE: reset is synchronous, so it is only tested inside the clocked block.
        if (!rst) q <= 1'b0;
        else      q <= d;
    end

endmodule

// File: rtl/sr_jk_t_using_d.sv
// SR, JK and T flip-flops built from D flops. Each requested next state is
// turned into SR/JK/T excitation, the three flops are driven through their
// characteristic equations, and a checker confirms all three reach the target.
// Optional feature: define FAULT_INJ_EN to add the inj port, which inverts the
// T excitation seen by the T flop while high.
// CNT_W must lie in 1..32.
module sr_jk_t_using_d
    import ff_conv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_d,
`ifdef FAULT_INJ_EN
    input  logic             inj,
`endif
    output logic             S,
    output logic             R,
    output logic             J,
    output logic             K,
    output logic             T,
    output logic             Qsr,
    output logic             Qjk,
    output logic             Qt,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tog_cnt,
    output logic             sr_illegal
);

    // Stage 0 and checker pipeline registers.
    logic tgt_q, tgt_d;
    logic vld_q, vld_d;
    logic chk_tgt_q, chk_tgt_d;
    logic chk_vld_q, chk_vld_d;

    // Counters.
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;

    // Checker FSM.
    ff_state_e state_q;
    logic      fault_q;

    // Flop D inputs and checker result.
    logic sr_d, jk_d, t_d, t_eff;
    logic mismatch;

    // Pipeline next-state: target and valid move one stage per cycle.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        tgt_d     = in_d;
        vld_d     = in_valid;
        chk_tgt_d = tgt_q;
        chk_vld_d = vld_q;
    end

    // Excitation from the registered target and each flop's present state;
    // all zero (every flop holds) when no target is pending.
    always_comb begin
        S = vld_q &  tgt_q & ~Qsr;
        R = vld_q & ~tgt_q &  Qsr;
        J = vld_q &  tgt_q;
        K = vld_q & ~tgt_q;
        T = vld_q & (tgt_q ^ Qt);
    end

    // Characteristic equations feeding the D flops.
    always_comb begin
        sr_d = S | (~R & Qsr);
        jk_d = (J & ~Qjk) | (~K & Qjk);
`ifdef FAULT_INJ_EN
        t_eff = T ^ inj;
`else
        t_eff = T;
`endif
        t_d = t_eff ^ Qt;
    end

    dff_cell u_sr (.clk(clk), .rst(rst), .d(sr_d), .q(Qsr));
    dff_cell u_jk (.clk(clk), .rst(rst), .d(jk_d), .q(Qjk));
    dff_cell u_t  (.clk(clk), .rst(rst), .d(t_d),  .q(Qt));

    // Compare all three flops against the target one cycle after excitation,
    // and advance the saturating counters.
    always_comb begin
        mismatch  = chk_vld_q & ((Qsr != chk_tgt_q) | (Qjk != chk_tgt_q) | (Qt != chk_tgt_q));
        err_cnt_d = mismatch ? CNT_W'(sat_inc(32'(err_cnt_q), CNT_W)) : err_cnt_q;
        tog_cnt_d = (jk_d != Qjk) ? CNT_W'(sat_inc(32'(tog_cnt_q), CNT_W)) : tog_cnt_q;
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tgt_q     <= 1'b0;
            vld_q     <= 1'b0;
            chk_tgt_q <= 1'b0;
            chk_vld_q <= 1'b0;
            err_cnt_q <= '0;
            tog_cnt_q <= '0;
        end else begin
            tgt_q     <= tgt_d;
            vld_q     <= vld_d;
            chk_tgt_q <= chk_tgt_d;
            chk_vld_q <= chk_vld_d;
            err_cnt_q <= err_cnt_d;
            tog_cnt_q <= tog_cnt_d;
        end
    end

    // Checker FSM: wait for the first target, then latch the first mismatch
    // into a FAULT state that only reset leaves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld_q) state_q <= RUN;
                end
                RUN: begin
                    if (mismatch) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end
                end
                FAULT: begin
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign fault      = fault_q;
    assign err_cnt    = err_cnt_q;
    assign tog_cnt    = tog_cnt_q;
    assign sr_illegal = S & R;

endmodule

// File: tb/tb_sr_jk_t_using_d.sv
// Scoreboard bench for sr_jk_t_using_d. Two instances share the stimulus:
// one with the default counter width and one with CNT_W=3 for saturation.
// The driver computes each cycle's expected view from a behavioural model and
// queues it; a monitor pops and compares after every rising edge.
// Define FAULT_INJ_EN to include the fault-injection scenario.
module tb_sr_jk_t_using_d;
    import ff_conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_d = 1'b0;
    logic inj = 1'b0;

    logic       s8, r8, j8, k8, t8, qsr8, qjk8, qt8, fault8, ill8;
    logic [7:0] err8, tog8;
    logic       s3, r3, j3, k3, t3, qsr3, qjk3, qt3, fault3, ill3;
    logic [2:0] err3, tog3;

    sr_jk_t_using_d #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_d(in_d),
`ifdef FAULT_INJ_EN
        .inj(inj),
`endif
        .S(s8), .R(r8), .J(j8), .K(k8), .T(t8),
        .Qsr(qsr8), .Qjk(qjk8), .Qt(qt8),
        .fault(fault8), .err_cnt(err8), .tog_cnt(tog8), .sr_illegal(ill8)
    );

    sr_jk_t_using_d #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_d(in_d),
`ifdef FAULT_INJ_EN
        .inj(inj),
`endif
        .S(s3), .R(r3), .J(j3), .K(k3), .T(t3),
        .Qsr(qsr3), .Qjk(qjk3), .Qt(qt3),
        .fault(fault3), .err_cnt(err3), .tog_cnt(tog3), .sr_illegal(ill3)
    );

    always #5 clk = ~clk;

    // Expected view of one cycle, taken just after the rising edge.
    typedef struct {
        logic        q;      // SR and JK flop value
        logic        qt;     // T flop value
        logic        s, r, j, k, t;
        logic        fault;
        int unsigned tog;    // unbounded counts; capped per instance on compare
        int unsigned err;
        ff_state_e   st;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: values the design should hold after the next edge.
    logic        m_q = 1'b0, m_qt = 1'b0, m_fault = 1'b0;
    logic        m_prev_v = 1'b0, m_prev_d = 1'b0;
    int unsigned m_tog = 0, m_err = 0;
    ff_state_e   m_st = IDLE;

    function automatic int unsigned cap(input int unsigned v, input int w);
        int unsigned m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the design must show after
    // the edge that samples it.
    task automatic step(input logic r_n, input logic v, input logic d, input logic ij);
        exp_t e;
        logic v_eff, mm, nq;
        @(negedge clk);
        rst      = r_n;
        in_valid = v;
        in_d     = d;
        inj      = ij;

        if (!r_n) begin
            m_q = 1'b0; m_qt = 1'b0; m_fault = 1'b0;
            m_prev_v = 1'b0; m_prev_d = 1'b0;
            m_tog = 0; m_err = 0; m_st = IDLE;
            v_eff = 1'b0;
        end else begin
            v_eff = v;
            // An injection pulse makes the T flop land on the opposite value.
            if (ij) m_qt = ~m_qt;
        end

        e.q     = m_q;
        e.qt    = m_qt;
        e.s     = v_eff & d & ~m_q;
        e.r     = v_eff & ~d & m_q;
        e.j     = v_eff & d;
        e.k     = v_eff & ~d;
        e.t     = v_eff & (d ^ m_qt);
        e.fault = m_fault;
        e.tog   = m_tog;
        e.err   = m_err;
        e.st    = m_st;
        sb_q.push_back(e);

        // The previous target is judged against the flops as they stand now.
        mm = m_prev_v && ((m_q != m_prev_d) || (m_qt != m_prev_d));
        if (mm) m_err++;
        m_fault = m_fault | mm;
        if (m_st == IDLE && v_eff)     m_st = RUN;
        else if (m_st == RUN && mm)    m_st = FAULT;

        nq = v_eff ? d : m_q;
        if (nq != m_q) m_tog++;
        m_q      = nq;
        m_qt     = v_eff ? d : m_qt;
        m_prev_v = v_eff;
        m_prev_d = d;
    endtask

    // Monitor: after each rising edge, compare both instances to the queued view.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("qsr",        32'(qsr8),  32'(e.q));
                check("qjk",        32'(qjk8),  32'(e.q));
                check("qt",         32'(qt8),   32'(e.qt));
                check("s",          32'(s8),    32'(e.s));
                check("r",          32'(r8),    32'(e.r));
                check("j",          32'(j8),    32'(e.j));
                check("k",          32'(k8),    32'(e.k));
                check("t",          32'(t8),    32'(e.t));
                check("sr_illegal", 32'(ill8),  32'd0);
                check("fault",      32'(fault8), 32'(e.fault));
                check("tog_cnt",    32'(tog8),  cap(e.tog, 8));
                check("err_cnt",    32'(err8),  cap(e.err, 8));
                check("state",      32'(dut8.state_q), 32'(e.st));
                check("tog_cnt_w3", 32'(tog3),  cap(e.tog, 3));
                check("err_cnt_w3", 32'(err3),  cap(e.err, 3));
                check("fault_w3",   32'(fault3), 32'(e.fault));
                check("qt_w3",      32'(qt3),   32'(e.qt));
            end
        end
    end

    // Stimulus sequence.
    initial begin
        // Reset held for two cycles while in_d toggles.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, i[0], 1'b0);

        // Back-to-back toggle stream, starting from 0.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i[0], 1'b0);

        // Hold at 1, then a gap with no valid target.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

        // Random targets with random gaps.
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

        // Fresh reset, then 12 toggles to saturate the narrow toggle counter.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, ~i[0], 1'b0);

`ifdef FAULT_INJ_EN
        // Single injection pulse inside a stream, then let it settle.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), (i == 4));
        // Further pulses push the narrow error counter into saturation.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), ~i[0]);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
`endif

        // Recovery: reset, then a clean random stream.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, i[0], 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);

        // Trailing idle cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Let the monitor drain the queue, bounded by a few cycles.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
